// File: rtl/expr_mem_engine_pkg.sv
// Shared types for the expression engine: op codes, FSM state encoding and default sizes.
package expr_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 8;

  typedef enum logic [1:0] {
    OP_MUL = 2'b00,
    OP_ADD = 2'b01,
    OP_SUB = 2'b10,
    OP_MAC = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WR_X = 3'd1,
    S_WR_Y = 3'd2,
    S_RD_X = 3'd3,
    S_RD_Y = 3'd4,
    S_EXEC = 3'd5,
    S_WR_R = 3'd6
  } state_e;
endpackage

// File: rtl/expr_mem_engine_if.sv
// Host-side bus of the expression engine: start/done handshake, operands and host read port.
interface expr_mem_engine_if
  import expr_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
);
  localparam int AW = $clog2(DEPTH);

  logic             start;
  op_e              op;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic [AW-1:0]    dst_addr;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             ovf;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] rd_data;

  modport master (
    output start, op, x, y, dst_addr, rd_addr,
    input  ready, done, result, ovf, rd_data
  );

  modport slave (
    input  start, op, x, y, dst_addr, rd_addr,
    output ready, done, result, ovf, rd_data
  );
endinterface

// File: rtl/expr_mem_engine_ram.sv
// Flop-based RAM with one write port and two registered read ports; reads see the pre-write word.
module expr_ram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_a_i,
  output logic [WIDTH-1:0] rdata_a_o,
  input  logic [AW-1:0]    raddr_b_i,
  output logic [WIDTH-1:0] rdata_b_o
);
  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [WIDTH-1:0]            rdata_a_q;
  logic [WIDTH-1:0]            rdata_b_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q     <= '0;
      rdata_a_q <= '0;
      rdata_b_q <= '0;
    end else begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      rdata_a_q <= mem_q[raddr_a_i];
      rdata_b_q <= mem_q[raddr_b_i];
    end
  end

  assign rdata_a_o = rdata_a_q;
  assign rdata_b_o = rdata_b_q;
endmodule

// File: rtl/expr_mem_engine.sv
// Expression engine: stores operands to RAM slots 0/1, re-reads them, runs MUL/ADD/SUB/MAC and
// writes the result to a caller-chosen slot with a one-cycle done pulse.
module expr_mem_engine
  import expr_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input logic              clk,
  input logic              rst,
  expr_mem_engine_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  localparam logic [2:0] IDLE = S_IDLE;
  localparam logic [2:0] WR_X = S_WR_X;
  localparam logic [2:0] WR_Y = S_WR_Y;
  localparam logic [2:0] RD_X = S_RD_X;
  localparam logic [2:0] RD_Y = S_RD_Y;
  localparam logic [2:0] EXEC = S_EXEC;
  localparam logic [2:0] WR_R = S_WR_R;

  logic [2:0]       state_q, state_d;
  logic [WIDTH-1:0] xq_q, yq_q, opa_q, res_q, acc_q, result_q;
  op_e              op_q;
  logic [AW-1:0]    dst_q;
  logic             rovf_q, done_q, ovf_q;

  logic             we;
  logic [AW-1:0]    waddr, raddr;
  logic [WIDTH-1:0] wdata, opb;

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH:0]     add_r, sub_r, mac_r;
  logic [WIDTH-1:0]   ex_res;
  logic               ex_ovf;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = WR_X;
      WR_X:    state_d = WR_Y;
      WR_Y:    state_d = RD_X;
      RD_X:    state_d = RD_Y;
      RD_Y:    state_d = EXEC;
      EXEC:    state_d = WR_R;
      WR_R:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    we    = 1'b0;
    waddr = '0;
    wdata = '0;
    case (state_q)
      WR_X: begin we = 1'b1; waddr = '0;      wdata = xq_q;  end
      WR_Y: begin we = 1'b1; waddr = AW'(1);  wdata = yq_q;  end
      WR_R: begin we = 1'b1; waddr = dst_q;   wdata = res_q; end
      default: ;
    endcase
  end

  // Slot 0 is addressed in RD_X, slot 1 otherwise; data lands one cycle later (RD_Y, EXEC).
  assign raddr = (state_q == RD_X) ? '0 : AW'(1);

  expr_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk       (clk),
    .rst       (rst),
    .we_i      (we),
    .waddr_i   (waddr),
    .wdata_i   (wdata),
    .raddr_a_i (raddr),
    .rdata_a_o (opb),
    .raddr_b_i (bus.rd_addr),
    .rdata_b_o (bus.rd_data)
  );

  assign prod  = {{WIDTH{1'b0}}, opa_q} * {{WIDTH{1'b0}}, opb};
  assign add_r = {1'b0, opa_q} + {1'b0, opb};
  assign sub_r = {1'b0, opa_q} - {1'b0, opb};
  assign mac_r = {1'b0, acc_q} + {1'b0, prod[WIDTH-1:0]};

  always_comb begin
    ex_res = '0;
    ex_ovf = 1'b0;
    case (op_q)
      OP_MUL: begin ex_res = prod[WIDTH-1:0];  ex_ovf = |prod[2*WIDTH-1:WIDTH]; end
      OP_ADD: begin ex_res = add_r[WIDTH-1:0]; ex_ovf = add_r[WIDTH]; end
      OP_SUB: begin ex_res = sub_r[WIDTH-1:0]; ex_ovf = sub_r[WIDTH]; end
      OP_MAC: begin ex_res = mac_r[WIDTH-1:0]; ex_ovf = mac_r[WIDTH]; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      xq_q     <= '0;
      yq_q     <= '0;
      op_q     <= OP_MUL;
      dst_q    <= '0;
      opa_q    <= '0;
      res_q    <= '0;
      rovf_q   <= 1'b0;
      acc_q    <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      if (state_q == IDLE && bus.start) begin
        xq_q  <= bus.x;
        yq_q  <= bus.y;
        op_q  <= bus.op;
        dst_q <= bus.dst_addr;
      end
      if (state_q == RD_Y) opa_q <= opb;
      if (state_q == EXEC) begin
        res_q  <= ex_res;
        rovf_q <= ex_ovf;
        if (op_q == OP_MAC) acc_q <= ex_res;
      end
      if (state_q == WR_R) begin
        done_q   <= 1'b1;
        result_q <= res_q;
        ovf_q    <= rovf_q;
      end
    end
  end

  assign bus.ready  = (state_q == IDLE);
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.ovf    = ovf_q;
endmodule

// File: tb/tb_expr_mem_engine.sv
// Directed bench for expr_mem_engine: a 32x8 instance for the main features and an 8x16 instance
// for the narrow-width / deep-RAM cases.
module tb_expr_mem_engine;
  import expr_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  expr_mem_engine_if #(.WIDTH(32), .DEPTH(8))  b0 ();
  expr_mem_engine_if #(.WIDTH(8),  .DEPTH(16)) b1 ();

  expr_mem_engine #(.WIDTH(32), .DEPTH(8))  u0 (.clk(clk), .rst(rst), .bus(b0));
  expr_mem_engine #(.WIDTH(8),  .DEPTH(16)) u1 (.clk(clk), .rst(rst), .bus(b1));

  // Launch one op on u0 and return the edge count from the accepting edge to the done cycle.
  task automatic op0(input op_e opc, input logic [31:0] xv, input logic [31:0] yv,
                     input logic [2:0] dst, output int lat);
    b0.op = opc; b0.x = xv; b0.y = yv; b0.dst_addr = dst; b0.start = 1'b1;
    @(posedge clk); #1;
    b0.start = 1'b0; b0.x = $urandom(); b0.y = $urandom(); b0.dst_addr = 3'($urandom());
    lat = 1;
    while (b0.done !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic op1(input op_e opc, input logic [7:0] xv, input logic [7:0] yv,
                     input logic [3:0] dst, output int lat);
    b1.op = opc; b1.x = xv; b1.y = yv; b1.dst_addr = dst; b1.start = 1'b1;
    @(posedge clk); #1;
    b1.start = 1'b0; b1.x = 8'($urandom()); b1.y = 8'($urandom());
    lat = 1;
    while (b1.done !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic rd0(input logic [2:0] a, output logic [31:0] d);
    b0.rd_addr = a;
    @(posedge clk); #1;
    d = b0.rd_data;
  endtask

  task automatic test_reset();
    int dcnt;
    logic [31:0] d;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    checks++; if (b0.ready !== 1'b1) begin errors++; $display("FAIL rst_ready got=%b exp=1", b0.ready); end
    checks++; if (b0.done !== 1'b0) begin errors++; $display("FAIL rst_done got=%b exp=0", b0.done); end
    checks++; if (b0.result !== 32'd0) begin errors++; $display("FAIL rst_result got=%h exp=0", b0.result); end
    checks++; if (b0.ovf !== 1'b0) begin errors++; $display("FAIL rst_ovf got=%b exp=0", b0.ovf); end
    // Start a MUL, then reset while in WR_Y (slot 0 already written).
    b0.op = OP_MUL; b0.x = 32'd6; b0.y = 32'd7; b0.dst_addr = 3'd2; b0.start = 1'b1;
    @(posedge clk); #1 b0.start = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    #1;
    checks++; if (b0.ready !== 1'b1) begin errors++; $display("FAIL rst_async_ready got=%b exp=1", b0.ready); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checks++; if (b0.done !== 1'b0 || b0.result !== 32'd0 || b0.ovf !== 1'b0)
      begin errors++; $display("FAIL rst_mid_outputs got=%b/%h/%b exp=0/0/0", b0.done, b0.result, b0.ovf); end
    dcnt = 0;
    repeat (10) begin @(posedge clk); #1; if (b0.done === 1'b1) dcnt++; end
    checks++; if (dcnt !== 0) begin errors++; $display("FAIL rst_no_done got=%0d exp=0", dcnt); end
    for (int i = 0; i < 8; i++) begin
      rd0(3'(i), d);
      checks++; if (d !== 32'd0) begin errors++; $display("FAIL rst_mem%0d got=%h exp=0", i, d); end
    end
  endtask

  task automatic test_mul();
    int lat;
    logic [31:0] d;
    op0(OP_MUL, 32'd6, 32'd7, 3'd2, lat);
    checks++; if (lat !== 7) begin errors++; $display("FAIL mul_latency got=%0d exp=7", lat); end
    checks++; if (b0.result !== 32'd42) begin errors++; $display("FAIL mul_result got=%0d exp=42", b0.result); end
    checks++; if (b0.ovf !== 1'b0) begin errors++; $display("FAIL mul_ovf got=%b exp=0", b0.ovf); end
    @(posedge clk); #1;
    checks++; if (b0.done !== 1'b0) begin errors++; $display("FAIL done_pulse got=%b exp=0", b0.done); end
    checks++; if (b0.result !== 32'd42) begin errors++; $display("FAIL result_hold got=%0d exp=42", b0.result); end
    rd0(3'd2, d);
    checks++; if (d !== 32'd42) begin errors++; $display("FAIL mul_mem2 got=%0d exp=42", d); end
    rd0(3'd0, d);
    checks++; if (d !== 32'd6) begin errors++; $display("FAIL mul_mem0 got=%0d exp=6", d); end
    rd0(3'd1, d);
    checks++; if (d !== 32'd7) begin errors++; $display("FAIL mul_mem1 got=%0d exp=7", d); end
  endtask

  task automatic test_overflow();
    int lat;
    op0(OP_MUL, 32'h0001_0000, 32'h0001_0000, 3'd3, lat);
    checks++; if (b0.result !== 32'd0 || b0.ovf !== 1'b1)
      begin errors++; $display("FAIL ovf_mul got=%h/%b exp=0/1", b0.result, b0.ovf); end
    op0(OP_ADD, 32'hFFFF_FFFF, 32'd1, 3'd3, lat);
    checks++; if (b0.result !== 32'd0 || b0.ovf !== 1'b1)
      begin errors++; $display("FAIL ovf_add got=%h/%b exp=0/1", b0.result, b0.ovf); end
    op0(OP_SUB, 32'd3, 32'd5, 3'd3, lat);
    checks++; if (b0.result !== 32'hFFFF_FFFE || b0.ovf !== 1'b1)
      begin errors++; $display("FAIL ovf_sub got=%h/%b exp=fffffffe/1", b0.result, b0.ovf); end
    op0(OP_SUB, 32'd9, 32'd4, 3'd3, lat);
    checks++; if (b0.result !== 32'd5 || b0.ovf !== 1'b0)
      begin errors++; $display("FAIL sub_plain got=%h/%b exp=5/0", b0.result, b0.ovf); end
  endtask

  task automatic test_mac();
    int lat;
    op0(OP_MAC, 32'd2, 32'd3, 3'd4, lat);
    checks++; if (b0.result !== 32'd6 || b0.ovf !== 1'b0)
      begin errors++; $display("FAIL mac1 got=%0d/%b exp=6/0", b0.result, b0.ovf); end
    op0(OP_MAC, 32'd4, 32'd5, 3'd5, lat);
    checks++; if (b0.result !== 32'd26) begin errors++; $display("FAIL mac2 got=%0d exp=26", b0.result); end
    op0(OP_ADD, 32'd100, 32'd1, 3'd6, lat);
    checks++; if (b0.result !== 32'd101 || b0.ovf !== 1'b0)
      begin errors++; $display("FAIL mac_add got=%0d/%b exp=101/0", b0.result, b0.ovf); end
    op0(OP_MAC, 32'd1, 32'd1, 3'd6, lat);
    checks++; if (b0.result !== 32'd27) begin errors++; $display("FAIL mac3 got=%0d exp=27", b0.result); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] dmask;
    logic [31:0] r6, r13, d;
    int extra, lat;
    dmask = '0; r6 = '0; r13 = '0; extra = 0;
    b0.op = OP_ADD; b0.y = 32'd0; b0.dst_addr = 3'd7; b0.x = 32'd10; b0.start = 1'b1;
    for (int k = 0; k < 14; k++) begin
      @(posedge clk); #1;
      if (b0.done === 1'b1) begin
        dmask[k] = 1'b1;
        if (k == 6)  r6  = b0.result;
        if (k == 13) r13 = b0.result;
      end
      b0.x = 32'(11 + k);
    end
    b0.start = 1'b0;
    repeat (8) begin @(posedge clk); #1; if (b0.done === 1'b1) extra++; end
    checks++; if (dmask !== 16'h2040) begin errors++; $display("FAIL hs_done_mask got=%h exp=2040", dmask); end
    checks++; if (r6 !== 32'd10) begin errors++; $display("FAIL hs_first got=%0d exp=10", r6); end
    checks++; if (r13 !== 32'd17) begin errors++; $display("FAIL hs_second got=%0d exp=17", r13); end
    checks++; if (extra !== 0) begin errors++; $display("FAIL hs_extra got=%0d exp=0", extra); end
    rd0(3'd7, d);
    checks++; if (d !== 32'd17) begin errors++; $display("FAIL hs_mem7 got=%0d exp=17", d); end
    op0(OP_ADD, 32'd5, 32'd6, 3'd0, lat);
    checks++; if (b0.result !== 32'd11) begin errors++; $display("FAIL dst0_result got=%0d exp=11", b0.result); end
    rd0(3'd0, d);
    checks++; if (d !== 32'd11) begin errors++; $display("FAIL dst0_mem0 got=%0d exp=11", d); end
    rd0(3'd1, d);
    checks++; if (d !== 32'd6) begin errors++; $display("FAIL dst0_mem1 got=%0d exp=6", d); end
  endtask

  task automatic test_param();
    int lat;
    b1.rd_addr = 4'd15;
    op1(OP_ADD, 8'hF0, 8'h20, 4'd15, lat);
    checks++; if (lat !== 7) begin errors++; $display("FAIL p_latency got=%0d exp=7", lat); end
    checks++; if (b1.result !== 8'h10 || b1.ovf !== 1'b1)
      begin errors++; $display("FAIL p_add_ovf got=%h/%b exp=10/1", b1.result, b1.ovf); end
    op1(OP_ADD, 8'h12, 8'h34, 4'd15, lat);
    checks++; if (b1.result !== 8'h46 || b1.ovf !== 1'b0)
      begin errors++; $display("FAIL p_add got=%h/%b exp=46/0", b1.result, b1.ovf); end
    op1(OP_MUL, 8'd16, 8'd16, 4'd15, lat);
    checks++; if (b1.result !== 8'h00 || b1.ovf !== 1'b1)
      begin errors++; $display("FAIL p_mul got=%h/%b exp=00/1", b1.result, b1.ovf); end
    checks++; if (b1.rd_data !== 8'h46) begin errors++; $display("FAIL p_collision_old got=%h exp=46", b1.rd_data); end
    @(posedge clk); #1;
    checks++; if (b1.rd_data !== 8'h00) begin errors++; $display("FAIL p_after_write got=%h exp=00", b1.rd_data); end
    b1.rd_addr = 4'd7;
    @(posedge clk); #1;
    checks++; if (b1.rd_data !== 8'h00) begin errors++; $display("FAIL p_no_wrap got=%h exp=00", b1.rd_data); end
  endtask

  initial begin
    b0.start = 1'b0; b0.op = OP_MUL; b0.x = '0; b0.y = '0; b0.dst_addr = '0; b0.rd_addr = '0;
    b1.start = 1'b0; b1.op = OP_MUL; b1.x = '0; b1.y = '0; b1.dst_addr = '0; b1.rd_addr = '0;
    test_reset();
    test_mul();
    test_overflow();
    test_mac();
    test_back_to_back();
    test_param();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
